// File: rtl/chien_par_pkg.sv
// Shared types and constant GF(2^M) helpers for the parallel Chien search.
// Pure compile-time content: no latency, no flow control.
// Constant functions only; safe to import anywhere.
package chien_par_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int MAX_M = 16;

    // mat[col] is the image of basis element x^col under multiplication by alpha^e.
    typedef logic [MAX_M-1:0][MAX_M-1:0] gf_mat_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int prim_poly(input int m);
        int p;
        case (m)
            2:       p = 'h7;
            3:       p = 'hb;
            4:       p = 'h13;
            5:       p = 'h25;
            6:       p = 'h43;
            7:       p = 'h89;
            8:       p = 'h11d;
            9:       p = 'h211;
            10:      p = 'h409;
            default: p = 'h13;
        endcase
        return p;
    endfunction

    // alpha^e as an M-bit polynomial-basis value; e is reduced mod 2^M-1.
    function automatic int lpow(input int m, input int e);
        int n;
        int k;
        int v;
        n = (1 << m) - 1;
        k = e % n;
        if (k < 0) k = k + n;
        v = 1;
        for (int s = 0; s < k; s++) begin
            v = v << 1;
            if (((v >> m) & 1) != 0) v = v ^ prim_poly(m);
        end
        return v;
    endfunction

    function automatic gf_mat_t gf_const_mat(input int m, input int e);
        gf_mat_t mat;
        mat = '0;
        for (int c = 0; c < m; c++) mat[c] = MAX_M'(lpow(m, e + c));
        return mat;
    endfunction

endpackage

// File: rtl/chien_par_gf_const_mult.sv
// Constant multiplier y = x * alpha^E over GF(2^M) as a fixed XOR network.
// Latency: combinational.
// Backpressure: none, pure function of x.
module gf_const_mult
    import chien_par_pkg::*;
#(
    parameter int M = 4,
    parameter int E = 0
) (
    input  logic [M-1:0] x,
    output logic [M-1:0] y
);

    localparam gf_mat_t MAT = gf_const_mat(M, E);

    always_comb begin
        y = '0;
        for (int c = 0; c < M; c++) begin
            if (x[c]) y = y ^ MAT[c][M-1:0];
        end
    end

endmodule

// File: rtl/chien_par.sv
// Parallel Chien search: PAR positions of sigma(alpha^k) per beat, root count and fail flag.
// Latency: first beat one cycle after start; done ceil(N/PAR)+1 cycles after start without stalls.
// Backpressure: out_ready low freezes the current beat, registers and outputs until accepted.
module chien_par
    import chien_par_pkg::*;
#(
    parameter int M   = 4,
    parameter int T   = 3,
    parameter int PAR = 1,
    parameter int N   = (1 << M) - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [M*(T+1)-1:0]      sigma,
    output logic                    ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PAR-1:0]          err,
    output logic                    out_last,
    output logic                    done,
    output logic [clog2(T+2)-1:0]   err_count,
    output logic                    fail
);

    localparam int NB   = (N + PAR - 1) / PAR;
    localparam int BW   = (NB > 1) ? clog2(NB) : 1;
    localparam int CW   = clog2(T + 2);
    localparam int CMAX = (1 << CW) - 1;
    localparam int DW   = (T > 0) ? clog2(T + 1) : 1;

    state_t          state;
    state_t          state_nxt;

    logic [M-1:0]    r_q   [T+1];
    logic [M-1:0]    r_nxt [T];
    logic [M-1:0]    tap   [PAR][T];
    logic [BW-1:0]   beat_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_nxt;
    logic [DW-1:0]   deg_q;
    logic [DW-1:0]   deg_in;
    logic            zero_q;
    logic            zero_in;
    logic            fail_q;
    logic            done_q;

    logic [PAR-1:0]  hit;
    logic [M-1:0]    acc;
    logic            hs;
    logic            last_beat;
    int              pop;
    int              sum;

    // Per-beat advance: r_i walks by alpha^(i*PAR) so the taps always see position b*PAR.
    for (genvar i = 1; i <= T; i++) begin : g_upd
        gf_const_mult #(.M(M), .E(i * PAR)) u_mul (
            .x (r_q[i]),
            .y (r_nxt[i-1])
        );
    end

    for (genvar j = 0; j < PAR; j++) begin : g_lane
        for (genvar i = 1; i <= T; i++) begin : g_tap
            gf_const_mult #(.M(M), .E(i * j)) u_mul (
                .x (r_q[i]),
                .y (tap[j][i-1])
            );
        end
    end

    always_comb begin
        hit = '0;
        acc = '0;
        for (int j = 0; j < PAR; j++) begin
            acc = r_q[0];
            for (int i = 0; i < T; i++) acc = acc ^ tap[j][i];
            hit[j] = (acc == '0) && ((int'(beat_q) * PAR + j) < N);
        end
    end

    always_comb begin
        pop = 0;
        for (int j = 0; j < PAR; j++) pop = pop + int'(hit[j]);
        sum = int'(cnt_q) + pop;
        cnt_nxt = (sum > CMAX) ? CW'(CMAX) : CW'(sum);
    end

    always_comb begin
        deg_in  = '0;
        zero_in = 1'b1;
        for (int i = 0; i <= T; i++) begin
            if (sigma[i*M +: M] != '0) begin
                deg_in  = DW'(i);
                zero_in = 1'b0;
            end
        end
    end

    assign last_beat = (beat_q == BW'(NB - 1));
    assign hs        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)           state_nxt = ST_RUN;
            ST_RUN:  if (hs && last_beat) state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == ST_IDLE);
        out_valid = (state == ST_RUN);
        err       = out_valid ? hit : '0;
        out_last  = out_valid && last_beat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= T; i++) r_q[i] <= '0;
            beat_q <= '0;
            cnt_q  <= '0;
            deg_q  <= '0;
            zero_q <= 1'b0;
            fail_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ready && start) begin
                for (int i = 0; i <= T; i++) r_q[i] <= sigma[i*M +: M];
                beat_q <= '0;
                cnt_q  <= '0;
                fail_q <= 1'b0;
                deg_q  <= deg_in;
                zero_q <= zero_in;
            end else if (hs) begin
                for (int i = 1; i <= T; i++) r_q[i] <= r_nxt[i-1];
                beat_q <= beat_q + BW'(1);
                cnt_q  <= cnt_nxt;
                if (last_beat) begin
                    done_q <= 1'b1;
                    fail_q <= zero_q || (int'(cnt_nxt) != int'(deg_q));
                end
            end
        end
    end

    assign done      = done_q;
    assign err_count = cnt_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_chien_par.sv
// Scoreboarded bench for chien_par (M=4, T=3, PAR=4, N=15) against a log/antilog GF(16) model.
module tb_chien_par;

    localparam int M   = 4;
    localparam int T   = 3;
    localparam int PAR = 4;
    localparam int N   = 15;
    localparam int NB  = 4;
    localparam int Q   = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] sigma;
    logic        ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  err;
    logic        out_last;
    logic        done;
    logic [2:0]  err_count;
    logic        fail;

    always #5 clk = ~clk;

    chien_par #(.M(M), .T(T), .PAR(PAR), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sigma     (sigma),
        .ready     (ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .out_last  (out_last),
        .done      (done),
        .err_count (err_count),
        .fail      (fail)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // GF(16) reference built from x^4+x+1 by repeated doubling.
    int alog [Q];
    int lg   [16];

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return alog[(lg[a] + lg[b]) % Q];
    endfunction

    function automatic int coef(input logic [15:0] s, input int i);
        return int'(s[i*4 +: 4]);
    endfunction

    function automatic int eval_at(input logic [15:0] s, input int k);
        int v = 0;
        for (int i = 0; i <= T; i++) v = v ^ gmul(coef(s, i), alog[(i * k) % Q]);
        return v;
    endfunction

    logic [3:0] q_err  [$];
    bit         q_last [$];
    int         q_cnt  [$];
    bit         q_fail [$];

    task automatic push_model(input logic [15:0] s);
        int roots = 0;
        int deg = 0;
        bit zero = 1;
        int cnt;
        logic [3:0] e;
        for (int b = 0; b < NB; b++) begin
            e = '0;
            for (int j = 0; j < PAR; j++) begin
                if (b * PAR + j < N && eval_at(s, b * PAR + j) == 0) begin
                    e[j] = 1'b1;
                    roots++;
                end
            end
            q_err.push_back(e);
            q_last.push_back(b == NB - 1);
        end
        for (int i = 0; i <= T; i++) if (coef(s, i) != 0) begin deg = i; zero = 0; end
        cnt = (roots > 7) ? 7 : roots;
        q_cnt.push_back(cnt);
        q_fail.push_back(zero || (cnt != deg));
    endtask

    bit         prev_stall = 0;
    logic [3:0] prev_err;
    logic       prev_last;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && out_valid) begin
                check("stall_err_stable", int'(err), int'(prev_err));
                check("stall_last_stable", int'(out_last), int'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_err   = err;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                if (q_err.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: err=%0h with empty scoreboard", err);
                end else begin
                    check("beat_err", int'(err), int'(q_err.pop_front()));
                    check("beat_last", int'(out_last), int'(q_last.pop_front()));
                end
            end
            if (done) begin
                if (q_cnt.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: err_count=%0d fail=%0d", err_count, fail);
                end else begin
                    check("err_count", int'(err_count), q_cnt.pop_front());
                    check("fail", int'(fail), int'(q_fail.pop_front()));
                    check("ready_on_done", int'(ready), 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rdy_pat(input int mode, input int c);
        if (mode == 1) return (c % 4 == 0) || (c % 4 == 3);
        if (mode == 2) return bit'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic launch(input logic [15:0] s);
        check("ready_before_start", int'(ready), 1);
        sigma = s;
        start = 1'b1;
        push_model(s);
        tick();
        start = 1'b0;
        check("ready_in_run", int'(ready), 0);
        check("first_beat_valid", int'(out_valid), 1);
    endtask

    task automatic wait_done(input int mode, input bit poke, output int cyc, output int stalls);
        bit got = 0;
        cyc = 0;
        stalls = 0;
        while (cyc < 60 && !got) begin
            cyc++;
            out_ready = rdy_pat(mode, cyc - 1);
            if (poke && cyc == 2) begin
                start = 1'b1;
                sigma = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (out_valid && !out_ready) stalls++;
            if (done) got = 1;
            else tick();
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end
    endtask

    task automatic run_case(input logic [15:0] s, input int mode, input bit poke);
        int cyc;
        int stalls;
        launch(s);
        wait_done(mode, poke, cyc, stalls);
        check("done_latency", cyc, NB + 1 + stalls);
        tick();
    endtask

    function automatic logic [15:0] rooted_sigma(input int r);
        int p [4];
        int np [4];
        int a;
        logic [15:0] s;
        p = '{1, 0, 0, 0};
        for (int t = 0; t < r; t++) begin
            a = alog[(Q - $urandom_range(0, Q - 1)) % Q];
            np[0] = p[0];
            for (int i = 1; i < 4; i++) np[i] = p[i] ^ gmul(a, p[i-1]);
            p = np;
        end
        for (int i = 0; i < 4; i++) s[i*4 +: 4] = 4'(p[i]);
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int v;
        int cyc;
        int stalls;
        int done_seen;

        v = 1;
        for (int i = 0; i < Q; i++) begin
            alog[i] = v;
            lg[v]   = i;
            v = v << 1;
            if (v & 16) v = v ^ 'h13;
        end
        lg[0] = 0;

        reset = 1'b1;
        start = 1'b0;
        sigma = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_ready", int'(ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_fail", int'(fail), 0);
        reset = 1'b0;
        tick();

        run_case(16'h0081, 0, 0);
        run_case(16'h0B21, 0, 1);
        run_case(16'h0111, 0, 0);
        run_case(16'h0B21, 1, 0);

        launch(16'h0B21);
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_err.delete();
        q_last.delete();
        q_cnt.delete();
        q_fail.delete();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_ready", int'(ready), 1);
        check("midrst_err_count", int'(err_count), 0);
        check("midrst_fail", int'(fail), 0);
        check("midrst_err", int'(err), 0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_seen++;
            tick();
        end
        check("midrst_no_done", done_seen, 0);
        run_case(16'h0B21, 0, 0);

        launch(16'h0000);
        wait_done(0, 1, cyc, stalls);
        check("zero_latency", cyc, NB + 1);
        launch(16'h0B21);
        wait_done(2, 0, cyc, stalls);
        check("chained_latency", cyc, NB + 1 + stalls);
        tick();

        for (int n = 0; n < 16; n++) begin
            if (n % 2 == 0) run_case(rooted_sigma($urandom_range(0, 3)), $urandom_range(0, 2), 0);
            else            run_case(16'($urandom_range(0, 16'hffff)), $urandom_range(0, 2), n % 3 == 0);
        end

        check("scoreboard_drained", q_err.size() + q_cnt.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
